// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between an I-cache line refill port and a D-side
// single-word port. One memory request is outstanding at a time; grants
// alternate round-robin when both sides request together.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; ready offered to the granted side
// I_REQ  | memory request for line word [beat] presented
// I_WAIT | waiting for read data of line word [beat]
// I_DONE | line assembled; i_resp_valid high for this one cycle
// D_REQ  | D-side read/write presented to memory
// D_WAIT | waiting for the D-side completion
module mem_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_req_valid,
   input  logic [ADDR_W-1:0]            i_req_addr,
   output logic                         i_req_ready,
   output logic                         i_resp_valid,
   output logic [LINE_WORDS*DATA_W-1:0] i_resp_line,
   input  logic                         d_req_valid,
   input  logic                         d_req_we,
   input  logic [ADDR_W-1:0]            d_req_addr,
   input  logic [DATA_W-1:0]            d_req_wdata,
   output logic                         d_req_ready,
   output logic                         d_resp_valid,
   output logic [DATA_W-1:0]            d_resp_rdata,
   output logic                         mem_valid,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   input  logic                         mem_ready,
   input  logic                         mem_rvalid,
   input  logic [DATA_W-1:0]            mem_rdata
);

   localparam int LINE_W = LINE_WORDS * DATA_W;
   localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam logic [ADDR_W-1:0] OFF_MASK   = {{(ADDR_W-OFF_W){1'b0}}, {OFF_W{1'b1}}};
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, I_REQ, I_WAIT, I_DONE, D_REQ, D_WAIT
   } state_t;

   state_t            state;
   logic [BEAT_W-1:0] beat;
   logic              last_d;   // last side served was D, so I wins the next tie
   logic              open;
   logic              grant_i;
   logic              grant_d;

   // Grant decision: only in IDLE, never while a D completion pulse is out,
   // I preferred on a tie unless it was served last.
   always_comb begin
      open    = 1'b0;
      grant_i = 1'b0;
      grant_d = 1'b0;
      open    = !rst && (state == IDLE) && !d_resp_valid;
      grant_i = open && i_req_valid && (!d_req_valid || last_d);
      grant_d = open && d_req_valid && !grant_i;
   end

   assign i_req_ready = grant_i;
   assign d_req_ready = grant_d;

   // Sequencer: state, beat counter, memory request fields and responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         beat         <= '0;
         last_d       <= 1'b1;
         i_resp_valid <= 1'b0;
         i_resp_line  <= '0;
         d_resp_valid <= 1'b0;
         d_resp_rdata <= '0;
         mem_valid    <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         i_resp_valid <= 1'b0;
         d_resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_i) begin
                  mem_addr  <= i_req_addr & ~OFF_MASK;
                  mem_we    <= 1'b0;
                  mem_valid <= 1'b1;
                  beat      <= '0;
                  state     <= I_REQ;
               end else if (grant_d) begin
                  mem_addr  <= d_req_addr;
                  mem_we    <= d_req_we;
                  mem_wdata <= d_req_wdata;
                  mem_valid <= 1'b1;
                  state     <= D_REQ;
               end
            end
            I_REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state     <= I_WAIT;
               end
            end
            I_WAIT: begin
               if (mem_rvalid) begin
                  i_resp_line[int'(beat)*DATA_W +: DATA_W] <= mem_rdata;
                  if (beat == LAST_BEAT) begin
                     i_resp_valid <= 1'b1;
                     state        <= I_DONE;
                  end else begin
                     beat      <= beat + 1'b1;
                     mem_addr  <= mem_addr + WORD_BYTES;
                     mem_valid <= 1'b1;
                     state     <= I_REQ;
                  end
               end
            end
            I_DONE: begin
               last_d <= 1'b0;
               state  <= IDLE;
            end
            D_REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state     <= D_WAIT;
               end
            end
            D_WAIT: begin
               if (mem_rvalid) begin
                  d_resp_valid <= 1'b1;
                  d_resp_rdata <= mem_rdata;
                  last_d       <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory with random stalls and
// response delays, and a transaction-level model of grants and results.
module tb_mem_arbiter;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 32;
   localparam int LW     = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req_valid;
   logic [ADDR_W-1:0] i_req_addr;
   logic              i_req_ready;
   logic              i_resp_valid;
   logic [127:0]      i_resp_line;
   logic              d_req_valid;
   logic              d_req_we;
   logic [ADDR_W-1:0] d_req_addr;
   logic [DATA_W-1:0] d_req_wdata;
   logic              d_req_ready;
   logic              d_resp_valid;
   logic [DATA_W-1:0] d_resp_rdata;
   logic              mem_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
      .i_resp_valid(i_resp_valid), .i_resp_line(i_resp_line),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory content: every word reads back as its address xor a per-test key.
   logic [31:0] key = 32'h0;
   function automatic logic [31:0] data_of(input logic [63:0] a);
      return a[31:0] ^ key;
   endfunction

   // Memory responder controls and request log.
   int          max_stall   = 0;
   int          max_extra   = 0;
   int          force_stall = -1;
   bit          hold_resp   = 1'b0;
   bit          spur_req    = 1'b0;
   logic [63:0] log_addr[$];
   logic        log_we[$];
   logic [31:0] log_wdata[$];

   bit          acc_flag = 1'b0;
   bit          pend     = 1'b0;
   bit          busy     = 1'b0;
   int          pend_wait  = 0;
   int          stall_left = 0;
   logic [31:0] acc_data  = '0;
   logic [31:0] pend_data = '0;

   initial begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         if (acc_flag) begin
            pend      = 1'b1;
            pend_wait = int'($urandom_range(0, max_extra));
            pend_data = acc_data;
            acc_flag  = 1'b0;
         end
         if (pend && !hold_resp) begin
            if (pend_wait == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = pend_data;
               pend       = 1'b0;
            end else pend_wait--;
         end
         if (spur_req && !mem_rvalid) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            spur_req   = 1'b0;
         end
         mem_ready = 1'b0;
         if (mem_valid === 1'b1) begin
            if (!busy) begin
               busy        = 1'b1;
               stall_left  = (force_stall >= 0) ? force_stall : int'($urandom_range(0, max_stall));
               force_stall = -1;
            end
            if (stall_left > 0) stall_left--;
            else begin
               mem_ready = 1'b1;
               acc_flag  = 1'b1;
               acc_data  = data_of(mem_addr);
               log_addr.push_back(mem_addr);
               log_we.push_back(mem_we);
               log_wdata.push_back(mem_wdata);
               busy = 1'b0;
            end
         end else busy = 1'b0;
      end
   end

   // Response monitor: cycle count, pulse-cycle counts, captured payloads.
   int          cyc = 0;
   int          i_hi = 0;
   int          d_hi = 0;
   int          i_resp_cyc = 0;
   logic [127:0] last_line = '0;
   logic [31:0]  last_rdata = '0;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (i_resp_valid === 1'b1) begin
            i_hi++;
            last_line  = i_resp_line;
            i_resp_cyc = cyc;
         end
         if (d_resp_valid === 1'b1) begin
            d_hi++;
            last_rdata = d_resp_rdata;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench did not complete");
   end

   // Model: side served last; D after reset so I wins the first tie.
   bit last_d = 1'b1;

   task automatic clear_log();
      log_addr.delete();
      log_we.delete();
      log_wdata.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_d = 1'b1;
   endtask

   // One complete transaction; mode 0 = I only, 1 = D only, 2 = both.
   // lat: edges from the handshake edge to the edge raising i_resp_valid.
   // wn:  cycles waited for a ready.
   task automatic run_txn(input int mode, input logic [63:0] ia, input logic [63:0] da,
                          input logic dwe, input logic [31:0] dwd, input bit spur,
                          output int lat, output int wn);
      logic [1:0]   rdy;
      logic [63:0]  base;
      logic [127:0] exp_line;
      bit           i_win;
      int           i0, d0, n, hs;
      i_win = (mode == 0) || (mode == 2 && last_d);
      clear_log();
      i0 = i_hi; d0 = d_hi; lat = -1;
      i_req_valid = (mode != 1); i_req_addr = ia;
      d_req_valid = (mode != 0); d_req_addr = da; d_req_we = dwe; d_req_wdata = dwd;
      #1;
      n = 0;
      while (i_req_ready !== 1'b1 && d_req_ready !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      wn  = n;
      rdy = {i_req_ready, d_req_ready};
      check("grant", rdy, i_win ? 2'b10 : 2'b01);
      hs = cyc + 1;
      @(negedge clk);
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      if (rdy == 2'b00) return;
      if (i_win) begin
         base = ia & ~64'hF;
         if (spur) begin
            check("spur_in_req", mem_valid, 1'b1);
            spur_req = 1'b1;
            repeat (2) @(negedge clk);
            check("spur_req_valid", mem_valid, 1'b1);
            check("spur_req_addr", mem_addr, base);
            check("spur_req_pulse", i_hi - i0, 0);
         end
         n = 0;
         while (i_hi == i0 && n < 300) begin @(negedge clk); n++; end
         check("i_resp_seen", i_hi != i0, 1'b1);
         lat = i_resp_cyc - hs;
         exp_line = '0;
         for (int k = 0; k < LW; k++) exp_line[32*k +: 32] = data_of(base + 64'(4*k));
         check("i_line", last_line, exp_line);
         check("i_nreq", log_addr.size(), LW);
         for (int k = 0; k < LW; k++) begin
            if (k < log_addr.size()) begin
               check("i_addr", log_addr[k], base + 64'(4*k));
               check("i_we", log_we[k], 1'b0);
            end
         end
         last_d = 1'b0;
      end else begin
         n = 0;
         while (d_hi == d0 && n < 300) begin @(negedge clk); n++; end
         check("d_resp_seen", d_hi != d0, 1'b1);
         check("d_nreq", log_addr.size(), 1);
         if (log_addr.size() > 0) begin
            check("d_addr", log_addr[0], da);
            check("d_we", log_we[0], dwe);
            check("d_wdata", log_wdata[0], dwd);
         end
         if (!dwe) check("d_rdata", last_rdata, data_of(da));
         last_d = 1'b1;
      end
      repeat (3) @(negedge clk);
      check("i_pulses", i_hi - i0, i_win ? 1 : 0);
      check("d_pulses", d_hi - d0, i_win ? 0 : 1);
   endtask

   initial begin
      int lat, wn, n, i0, d0;
      logic [63:0] a, b;

      // Reset with both valids high: everything held at zero.
      rst = 1'b1;
      i_req_valid = 1'b1; i_req_addr = 64'h1234;
      d_req_valid = 1'b1; d_req_addr = 64'h5678; d_req_we = 1'b1; d_req_wdata = 32'h1;
      repeat (3) @(negedge clk);
      check("rst_i_ready", i_req_ready, 1'b0);
      check("rst_d_ready", d_req_ready, 1'b0);
      check("rst_i_resp", i_resp_valid, 1'b0);
      check("rst_d_resp", d_resp_valid, 1'b0);
      check("rst_mem_valid", mem_valid, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 64'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_line", i_resp_line, 128'h0);
      check("rst_rdata", d_resp_rdata, 32'h0);
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      rst = 1'b0;
      last_d = 1'b1;
      @(negedge clk);

      // Zero-wait refill returning address as data. Counting the handshake
      // cycle as cycle 1, the pulse lands in cycle 10: 8 edges later.
      key = 32'h0; max_stall = 0; max_extra = 0;
      run_txn(0, 64'h8000_1238, 64'h0, 1'b0, 32'h0, 1'b0, lat, wn);
      check("refill_latency", lat, 8);
      check("refill_line", last_line, 128'h8000123C_80001238_80001234_80001230);

      // Tie after reset: I first, D in the first IDLE after the I pulse.
      do_reset();
      key = $urandom;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      clear_log();
      i0 = i_hi; d0 = d_hi;
      i_req_valid = 1'b1; i_req_addr = a;
      d_req_valid = 1'b1; d_req_addr = b; d_req_we = 1'b0; d_req_wdata = 32'h0;
      #1;
      check("tie_first", {i_req_ready, d_req_ready}, 2'b10);
      @(negedge clk);
      i_req_valid = 1'b0;
      n = 0;
      while (i_hi == i0 && n < 100) begin @(negedge clk); n++; end
      check("tie_i_pulse", i_resp_valid, 1'b1);
      check("tie_d_held", d_req_ready, 1'b0);
      @(negedge clk); #1;
      check("tie_d_grant", {i_req_ready, d_req_ready}, 2'b01);
      @(negedge clk);
      d_req_valid = 1'b0;
      n = 0;
      while (d_hi == d0 && n < 100) begin @(negedge clk); n++; end
      check("tie_d_rdata", last_rdata, data_of(b));
      last_d = 1'b1;
      repeat (2) @(negedge clk);
      run_txn(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 32'h0, 1'b0, lat, wn);

      // D write under three stall cycles: request held four cycles.
      force_stall = 3; max_extra = 0;
      clear_log();
      d0 = d_hi;
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 64'h100; d_req_wdata = 32'hDEADBEEF;
      #1;
      n = 0;
      while (d_req_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      check("wr_grant", d_req_ready, 1'b1);
      @(negedge clk);
      d_req_valid = 1'b0;
      n = 0;
      while (mem_valid === 1'b1 && n < 10) begin
         check("wr_addr", mem_addr, 64'h100);
         check("wr_wdata", mem_wdata, 32'hDEADBEEF);
         check("wr_we", mem_we, 1'b1);
         n++;
         @(negedge clk);
      end
      check("wr_valid_cycles", n, 4);
      n = 0;
      while (d_hi == d0 && n < 100) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      check("wr_pulses", d_hi - d0, 1);
      last_d = 1'b1;

      // Spurious read responses in IDLE and in I_REQ.
      i0 = i_hi; d0 = d_hi;
      spur_req = 1'b1;
      repeat (3) @(negedge clk);
      check("spur_idle_i", i_hi - i0, 0);
      check("spur_idle_d", d_hi - d0, 0);
      check("spur_idle_memv", mem_valid, 1'b0);
      key = $urandom; force_stall = 4;
      run_txn(0, {$urandom, $urandom}, 64'h0, 1'b0, 32'h0, 1'b1, lat, wn);

      // Reset in I_WAIT of the third beat, late response afterwards.
      key = $urandom; max_stall = 0; max_extra = 0;
      clear_log();
      i0 = i_hi;
      i_req_valid = 1'b1; i_req_addr = {$urandom, $urandom};
      #1;
      n = 0;
      while (i_req_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      i_req_valid = 1'b0;
      n = 0;
      while (log_addr.size() < 3 && n < 50) begin @(negedge clk); n++; end
      hold_resp = 1'b1;
      @(negedge clk);
      check("abort_in_wait", mem_valid, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_memv", mem_valid, 1'b0);
      check("abort_addr", mem_addr, 64'h0);
      check("abort_i_resp", i_resp_valid, 1'b0);
      rst = 1'b0;
      hold_resp = 1'b0;
      last_d = 1'b1;
      run_txn(1, 64'h0, {$urandom, $urandom}, 1'b0, 32'h0, 1'b0, lat, wn);
      check("abort_idle_grant_wait", wn, 0);
      check("abort_no_i_pulse", i_hi - i0, 0);

      // Randomized mix of single and contending requests.
      for (int t = 0; t < 40; t++) begin
         key       = $urandom;
         max_stall = int'($urandom_range(0, 3));
         max_extra = int'($urandom_range(0, 2));
         run_txn(int'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), $urandom, 1'b0, lat, wn);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning byte-address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning memory word width.
REQ-003 SHALL have parameter LINE_WORDS, default 4, meaning words per I-side line refill (line = LINE_WORDS*DATA_W = 128 bits).
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports i_req_valid in 1, i_req_addr in ADDR_W, i_req_ready out 1: I-cache line refill request.
REQ-007 SHALL have ports i_resp_valid out 1, i_resp_line out 128: refilled line, word k at bits [32k+31:32k].
REQ-008 SHALL have ports d_req_valid in 1, d_req_we in 1, d_req_addr in ADDR_W, d_req_wdata in DATA_W, d_req_ready out 1: D-side single-word access.
REQ-009 SHALL have ports d_resp_valid out 1, d_resp_rdata out DATA_W: D-side completion (read data; write acknowledge with rdata don't-care).
REQ-010 SHALL have ports mem_valid out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_ready in 1: shared memory request channel.
REQ-011 SHALL have ports mem_rvalid in 1, mem_rdata in DATA_W: memory response, one per accepted request, arriving ≥1 cycle after acceptance.

Function
REQ-012 SHALL be an FSM with states IDLE, I_REQ, I_WAIT, I_DONE, D_REQ, D_WAIT.
REQ-013 SHALL in IDLE assert exactly one of i_req_ready/d_req_ready toward the granted requester, and neither if no valid is high; both readys low in all other states.
REQ-014 SHALL grant round-robin: with both valid, grant the side not served last; single valid is granted immediately; after reset the I-side has priority.
REQ-015 SHALL on I handshake (i_req_valid && i_req_ready) latch i_req_addr with bits [3:0] forced to 0, clear beat counter, go to I_REQ.
REQ-016 SHALL on D handshake latch d_req_we, d_req_addr, d_req_wdata and go to D_REQ.
REQ-017 SHALL in I_REQ drive mem_valid=1, mem_we=0, mem_addr=base+4*beat; on mem_ready go to I_WAIT.
REQ-018 SHALL in I_WAIT on mem_rvalid store mem_rdata into line word[beat]; if beat==LINE_WORDS-1 go to I_DONE, else increment beat (2-bit counter) and return to I_REQ.
REQ-019 SHALL in I_DONE assert i_resp_valid for exactly one cycle with the assembled line, update last-served to I, return to IDLE.
REQ-020 SHALL in D_REQ drive mem_valid=1 with latched we/addr/wdata; on mem_ready go to D_WAIT.
REQ-021 SHALL in D_WAIT on mem_rvalid assert d_resp_valid for exactly one cycle (registered, next cycle) with d_resp_rdata=mem_rdata, update last-served to D, return to IDLE.
REQ-022 SHALL hold mem_valid and all mem_* request fields stable from assertion until mem_ready; mem_valid low in IDLE, *_WAIT, I_DONE.
REQ-023 SHALL ignore mem_rvalid in IDLE, I_REQ, D_REQ, I_DONE (no state change, no response pulse).
REQ-024 SHALL keep one memory request outstanding at most; minimum refill latency with zero-wait memory = 1 (accept) + 4×2 + 1 = 10 cycles from I handshake to i_resp_valid.
REQ-025 SHALL allow a new request to be granted in the cycle after return to IDLE (no back-to-back grant in the same cycle as a response pulse).
REQ-026 SHALL not require input valids to be held after handshake; deassertion of a valid before handshake withdraws the request without effect.

Reset
REQ-027 SHALL on rst: state=IDLE, beat=0, last-served=D (so I wins first tie), all outputs 0 (readys, resp_valids, mem_valid, mem_we, addresses, data, line).
REQ-028 SHALL on rst mid-transaction abort immediately with no response pulse; a memory response arriving afterward is dropped per REQ-023.

Verification
REQ-029 SHALL pass: I req addr 0x8000_1238, zero-wait memory returning addr as data -> mem_addr 0x..1230,0x..1234,0x..1238,0x..123C; i_resp_line = {0x..123C,0x..1238,0x..1234,0x..1230} at cycle 10.
REQ-030 SHALL pass: I and D valid simultaneously after reset -> I served first, D granted in first IDLE after i_resp_valid; next tie grants I.
REQ-031 SHALL pass: D write addr 0x100 data 0xDEADBEEF, mem_ready low 3 cycles -> mem_valid/addr/wdata/we=1 stable 4 cycles, one d_resp_valid pulse after mem_rvalid.
REQ-032 SHALL pass: rst asserted in I_WAIT after beat 2 -> IDLE next cycle, no i_resp_valid, late mem_rvalid ignored, new D request then serviced normally.
REQ-033 SHALL pass: spurious mem_rvalid in IDLE and I_REQ -> no state change, no response pulse, beat unchanged.
